// File: rtl/add_sub_reservation_station.sv
// ============================================================================
//  Module      : add_sub_reservation_station
//  Description : Reservation station feeding the add/sub execution unit.
//                Holds dispatched instructions, snoops the result bus for
//                missing operands and issues ready work in index order.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package add_sub_pkg;

    typedef struct packed {
        logic subtract;      // rD = op2 - op1 (op1 inverted, carry-in of one)
        logic use_xer_ca;    // extended forms take carry-in from XER[CA]
        logic carry_in_one;  // constant carry-in when XER is not used
        logic set_ca;        // update XER[CA]
        logic set_ov;        // update XER[OV]/XER[SO]
        logic set_cr0;       // record form
    } add_sub_decode_t;

endpackage

module add_sub_reservation_station
    import add_sub_pkg::*;
#(
    parameter int RS_ID_WIDTH = 5,
    parameter int ENTRIES     = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   dispatch_valid,
    output logic                   dispatch_ready,
    input  logic [RS_ID_WIDTH-1:0] dispatch_rs_id,
    input  logic [4:0]             dispatch_result_reg_addr,
    input  add_sub_decode_t        dispatch_control,
    input  logic [31:0]            dispatch_op1_value,
    input  logic [31:0]            dispatch_op2_value,
    input  logic [31:0]            dispatch_xer_value,
    input  logic                   dispatch_op1_ready,
    input  logic                   dispatch_op2_ready,
    input  logic                   dispatch_xer_ready,
    input  logic [RS_ID_WIDTH-1:0] dispatch_op1_tag,
    input  logic [RS_ID_WIDTH-1:0] dispatch_op2_tag,
    input  logic [RS_ID_WIDTH-1:0] dispatch_xer_tag,

    input  logic                   cdb_valid,
    input  logic [RS_ID_WIDTH-1:0] cdb_rs_id,
    input  logic [31:0]            cdb_result,
    input  logic                   cdb_xer_valid,
    input  logic [31:0]            cdb_xer,

    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [RS_ID_WIDTH-1:0] issue_rs_id,
    output logic [4:0]             issue_result_reg_addr,
    output logic [31:0]            issue_op1,
    output logic [31:0]            issue_op2,
    output logic [31:0]            issue_xer,
    output add_sub_decode_t        issue_control
);

    localparam int c_IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int c_NUM_OPS = 3;   // 0 = op1, 1 = op2, 2 = xer

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0]     r_busy;
    logic [RS_ID_WIDTH-1:0] r_rs_id    [ENTRIES];
    logic [4:0]             r_reg_addr [ENTRIES];
    add_sub_decode_t        r_control  [ENTRIES];
    logic [31:0]            r_op_val   [ENTRIES][c_NUM_OPS];
    logic [RS_ID_WIDTH-1:0] r_op_tag   [ENTRIES][c_NUM_OPS];
    logic [c_NUM_OPS-1:0]   r_op_rdy   [ENTRIES];

    logic                   r_issue_valid;
    logic [RS_ID_WIDTH-1:0] r_issue_rs_id;
    logic [4:0]             r_issue_reg_addr;
    logic [31:0]            r_issue_op1;
    logic [31:0]            r_issue_op2;
    logic [31:0]            r_issue_xer;
    add_sub_decode_t        r_issue_control;

    // ------------------------------------------------------------------
    // Per-operand views of the dispatch port and the result bus
    // ------------------------------------------------------------------
    logic [31:0]            w_disp_val [c_NUM_OPS];
    logic [RS_ID_WIDTH-1:0] w_disp_tag [c_NUM_OPS];
    logic [c_NUM_OPS-1:0]   w_disp_rdy;
    logic [31:0]            w_cdb_val  [c_NUM_OPS];
    logic [c_NUM_OPS-1:0]   w_cdb_ok;

    assign w_disp_val[0] = dispatch_op1_value;
    assign w_disp_val[1] = dispatch_op2_value;
    assign w_disp_val[2] = dispatch_xer_value;
    assign w_disp_tag[0] = dispatch_op1_tag;
    assign w_disp_tag[1] = dispatch_op2_tag;
    assign w_disp_tag[2] = dispatch_xer_tag;
    assign w_disp_rdy    = {dispatch_xer_ready, dispatch_op2_ready, dispatch_op1_ready};

    // The XER operand only listens to broadcasts that actually carry an XER value
    assign w_cdb_val[0]  = cdb_result;
    assign w_cdb_val[1]  = cdb_result;
    assign w_cdb_val[2]  = cdb_xer;
    assign w_cdb_ok      = {cdb_valid & cdb_xer_valid, cdb_valid, cdb_valid};

    // ------------------------------------------------------------------
    // Free-entry and eligible-entry selection (lowest index wins)
    // ------------------------------------------------------------------
    logic [ENTRIES-1:0] w_eligible;
    logic [c_IDX_W-1:0] w_free_idx;
    logic               w_any_free;
    logic [c_IDX_W-1:0] w_sel_idx;
    logic               w_any_elig;
    logic               w_load;
    logic               w_issue_fire;
    logic               w_disp_fire;

    for (genvar g = 0; g < ENTRIES; g++) begin : g_eligible
        assign w_eligible[g] = r_busy[g] & (&r_op_rdy[g]);
    end

    always_comb begin
        w_free_idx = '0;
        w_any_free = 1'b0;
        w_sel_idx  = '0;
        w_any_elig = 1'b0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_idx = c_IDX_W'(i);
                w_any_free = 1'b1;
            end
            if (w_eligible[i]) begin
                w_sel_idx  = c_IDX_W'(i);
                w_any_elig = 1'b1;
            end
        end
    end

    assign w_load         = ~r_issue_valid | issue_ready;
    assign w_issue_fire   = w_load & w_any_elig;
    assign w_disp_fire    = dispatch_valid & w_any_free;
    assign dispatch_ready = w_any_free;

    // ------------------------------------------------------------------
    // Occupancy: a slot freed by issue is never the slot being written,
    // since dispatch only targets entries that were free before the edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (w_disp_fire && (w_free_idx == c_IDX_W'(e))) begin
                    r_busy[e] <= 1'b1;
                end else if (w_issue_fire && (w_sel_idx == c_IDX_W'(e))) begin
                    r_busy[e] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry payload: dispatch write with same-cycle bypass, else wake-up
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int e = 0; e < ENTRIES; e++) begin
            if (w_disp_fire && (w_free_idx == c_IDX_W'(e))) begin
                r_rs_id[e]    <= dispatch_rs_id;
                r_reg_addr[e] <= dispatch_result_reg_addr;
                r_control[e]  <= dispatch_control;
                for (int op = 0; op < c_NUM_OPS; op++) begin
                    r_op_tag[e][op] <= w_disp_tag[op];
                    if (w_disp_rdy[op]) begin
                        r_op_val[e][op] <= w_disp_val[op];
                        r_op_rdy[e][op] <= 1'b1;
                    end else if (w_cdb_ok[op] && (cdb_rs_id == w_disp_tag[op])) begin
                        r_op_val[e][op] <= w_cdb_val[op];
                        r_op_rdy[e][op] <= 1'b1;
                    end else begin
                        r_op_rdy[e][op] <= 1'b0;
                    end
                end
            end else if (r_busy[e]) begin
                for (int op = 0; op < c_NUM_OPS; op++) begin
                    if (!r_op_rdy[e][op] && w_cdb_ok[op] &&
                        (cdb_rs_id == r_op_tag[e][op])) begin
                        r_op_val[e][op] <= w_cdb_val[op];
                        r_op_rdy[e][op] <= 1'b1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue register: refills whenever empty or being accepted
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_valid    <= 1'b0;
            r_issue_rs_id    <= '0;
            r_issue_reg_addr <= '0;
            r_issue_op1      <= '0;
            r_issue_op2      <= '0;
            r_issue_xer      <= '0;
            r_issue_control  <= '0;
        end else if (w_load) begin
            r_issue_valid <= w_any_elig;
            if (w_any_elig) begin
                r_issue_rs_id    <= r_rs_id[w_sel_idx];
                r_issue_reg_addr <= r_reg_addr[w_sel_idx];
                r_issue_op1      <= r_op_val[w_sel_idx][0];
                r_issue_op2      <= r_op_val[w_sel_idx][1];
                r_issue_xer      <= r_op_val[w_sel_idx][2];
                r_issue_control  <= r_control[w_sel_idx];
            end
        end
    end

    assign issue_valid           = r_issue_valid;
    assign issue_rs_id           = r_issue_rs_id;
    assign issue_result_reg_addr = r_issue_reg_addr;
    assign issue_op1             = r_issue_op1;
    assign issue_op2             = r_issue_op2;
    assign issue_xer             = r_issue_xer;
    assign issue_control         = r_issue_control;

endmodule

`default_nettype wire
